// File: rtl/pipe_mem_resp.sv
// pipe_mem_resp: single-port memory responder at the memory side of the pipeline's
// valid/ready request/response channels. One request is in flight at a time. Each request is
// a word read or a byte-strobed write, and it is performed after a fixed latency.
// Optional feature macro: PIPE_MEM_B2B_EN. When defined, the next request can be accepted in
// the same cycle that the current response handshakes.
module pipe_mem_resp #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter int                    LATENCY     = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_wen_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [3:0]            CNT_LOAD    = 4'(LATENCY - 1);

`ifdef PIPE_MEM_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;

    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_wen;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [STRB_W-1:0]       lat_wstrb;

    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic                    accept;
    logic                    do_access;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic                    acc_wen;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [STRB_W-1:0]       acc_wstrb;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   idx_full;
    logic [IDX_W-1:0]        idx;
    logic                    acc_err;
    logic                    mem_we;

    // Request acceptance: always ready in IDLE. With back-to-back enabled, the responder is
    // also ready in RESP whenever the response is being taken this cycle.
    always_comb begin
        req_ready_o = 1'b0;
        if (state == IDLE) begin
            req_ready_o = 1'b1;
        end else if (B2B && (state == RESP)) begin
            req_ready_o = resp_ready_i;
        end
    end

    assign accept = req_valid_i & req_ready_o;

    // Choose which request the access uses and decode its word index and error condition.
    // With LATENCY=1, the access happens on the accept edge, so the live request is used.
    // Otherwise the latched copy is used.
    always_comb begin
        acc_addr  = lat_addr;
        acc_wen   = lat_wen;
        acc_wdata = lat_wdata;
        acc_wstrb = lat_wstrb;
        if (accept) begin
            acc_addr  = req_addr_i;
            acc_wen   = req_wen_i;
            acc_wdata = req_wdata_i;
            acc_wstrb = req_wstrb_i;
        end
        offset    = acc_addr - BASE_ADDR;
        idx_full  = offset >> OFF_W;
        idx       = idx_full[IDX_W-1:0];
        acc_err   = (|acc_addr[OFF_W-1:0]) | (idx_full >= DEPTH_LIMIT);
        do_access = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
        mem_we    = do_access & acc_wen & ~acc_err;
    end

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    if (accept) begin
                        state_next = (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latency counter, latched request and registered response.
    // The response registers change only on an access edge, so they stay stable under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_addr  <= req_addr_i;
                lat_wen   <= req_wen_i;
                lat_wdata <= req_wdata_i;
                lat_wstrb <= req_wstrb_i;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                err_q <= acc_err;
                if (acc_err || acc_wen) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= mem[idx];
                end
            end
        end
    end

    // Storage array. It is not reset. Only in-range, aligned writes update the selected bytes.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (acc_wstrb[k]) begin
                    mem[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

    assign resp_valid_o = (state == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_pipe_mem_resp.sv
// Testbench for pipe_mem_resp. It runs three instances (LATENCY 1, 3 and 4) side by side on
// shared request inputs. Each scenario task checks only the instance it targets.
module tb_pipe_mem_resp;

    localparam int LAT [3] = '{1, 3, 4};

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;

    logic [2:0]  ready;
    logic [2:0]  valid;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    int checks = 0;
    int errors = 0;

    pipe_mem_resp #(.LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready[0]),
        .req_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .resp_valid_o(valid[0]), .resp_ready_i(resp_ready),
        .resp_rdata_o(rdata[0]), .resp_err_o(err[0])
    );

    pipe_mem_resp #(.LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready[1]),
        .req_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .resp_valid_o(valid[1]), .resp_ready_i(resp_ready),
        .resp_rdata_o(rdata[1]), .resp_err_o(err[1])
    );

    pipe_mem_resp #(.LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready[2]),
        .req_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .resp_valid_o(valid[2]), .resp_ready_i(resp_ready),
        .resp_rdata_o(rdata[2]), .resp_err_o(err[2])
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Issue one request to instance s, wait for its response with resp_ready held high, and
    // return the response fields. Latency, and ready during RESP, are checked here.
    task automatic do_txn(input int s, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rd, output logic er);
        int cyc;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wstrb  = wstrb;
        resp_ready = 1'b1;
        cyc = 0;
        while (ready[s] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (ready[s] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout inst%0d: ready=%b required 1", s, ready[s]);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (valid[s] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== LAT[s]) begin
            errors++;
            $display("[TB] FAIL latency inst%0d addr=%h: got %0d required %0d", s, addr, cyc, LAT[s]);
        end
        checks++;
`ifdef PIPE_MEM_B2B_EN
        if (ready[s] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_in_resp inst%0d: got %b required 1", s, ready[s]);
        end
`else
        if (ready[s] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_in_resp inst%0d: got %b required 0", s, ready[s]);
        end
`endif
        rd = rdata[s];
        er = err[s];
        @(posedge clk);
        #1;
    endtask

    // Hold reset for 3 cycles, then check the idle outputs of every instance.
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks += 4;
            if (ready[s] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_ready inst%0d: got %b required 1", s, ready[s]);
            end
            if (valid[s] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid inst%0d: got %b required 0", s, valid[s]);
            end
            if (rdata[s] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_rdata inst%0d: got %h required 0", s, rdata[s]);
            end
            if (err[s] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_err inst%0d: got %b required 0", s, err[s]);
            end
        end
        rst = 1'b0;
    endtask

    // Full and partial byte-strobed writes on the LATENCY=1 instance, each followed by a read.
    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd [5] = '{32'h0, 32'hDEADBEEF, 32'hDEAD3344, 32'hDEAD3344, 32'hABAD3344};
        logic [31:0] wd     [5] = '{32'h0, 32'hDEADBEEF, 32'h11223344, 32'hFFFFFFFF, 32'hAB000000};
        logic [3:0]  ws     [5] = '{4'h0, 4'hF, 4'h3, 4'h0, 4'h8};
        for (int i = 1; i < 5; i++) begin
            do_txn(0, 1'b1, 32'h8000_0010, wd[i], ws[i], rd, er);
            checks++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                errors++;
                $display("[TB] FAIL write_resp%0d: rdata=%h err=%b required 0/0", i, rd, er);
            end
            do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
            checks++;
            if (rd !== exp_rd[i] || er !== 1'b0) begin
                errors++;
                $display("[TB] FAIL read_back%0d: rdata=%h err=%b required %h/0", i, rd, er, exp_rd[i]);
            end
        end
    endtask

    // Misaligned, below-base and past-end accesses must error without touching storage.
    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        logic [31:0] err_addr [4] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_0001};
        logic        err_wen  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_txn(0, 1'b1, 32'h8000_0000, 32'h600DCAFE, 4'hF, rd, er);
        do_txn(0, 1'b1, 32'h8000_3FFC, 32'h5A5A1234, 4'hF, rd, er);
        for (int i = 0; i < 4; i++) begin
            do_txn(0, err_wen[i], err_addr[i], 32'hFFFFFFFF, 4'hF, rd, er);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("[TB] FAIL err_access addr=%h: rdata=%h err=%b required 0/1", err_addr[i], rd, er);
            end
        end
        do_txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h600DCAFE || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_no_write word0: rdata=%h err=%b required 600dcafe/0", rd, er);
        end
        do_txn(0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h5A5A1234 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_word: rdata=%h err=%b required 5a5a1234/0", rd, er);
        end
    endtask

    // LATENCY=3: a read held under 5 cycles of backpressure stays valid and stable,
    // with req_ready low throughout.
    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        do_txn(1, 1'b1, 32'h8000_0040, 32'hA5A55A5A, 4'hF, rd, er);
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 32'h8000_0040;
        resp_ready = 1'b0;
        cyc = 0;
        while (ready[1] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (valid[1] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d required 3", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid[1] !== 1'b1 || rdata[1] !== 32'hA5A55A5A || err[1] !== 1'b0 || ready[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b required 1/a5a55a5a/0/0",
                         i, valid[1], rdata[1], err[1], ready[1]);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b0 || ready[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: valid=%b ready=%b required 0/1", valid[1], ready[1]);
        end
    endtask

    // LATENCY=4: reset one cycle after a write is accepted. The write must be dropped and
    // no response issued.
    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        logic        seen;
        do_txn(2, 1'b1, 32'h8000_0020, 32'hCAFEF00D, 4'hF, rd, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'h0BADBEEF;
        req_wstrb = 4'hF;
        cyc = 0;
        while (ready[2] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (valid[2] !== 1'b0 || ready[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_reset_state: valid=%b ready=%b required 0/1", valid[2], ready[2]);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid[2] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_no_resp: response seen=%b required 0", seen);
        end
        do_txn(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_prior_data: rdata=%h err=%b required cafef00d/0", rd, er);
        end
    endtask

    // Stream 8 reads on LATENCY=1 with valid and resp_ready held high. Responses must come back
    // in order: every cycle with back-to-back enabled, otherwise every second cycle.
    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_data [8];
        int          req_i;
        int          nresp;
`ifdef PIPE_MEM_B2B_EN
        int          stride = 1;
`else
        int          stride = 2;
`endif
        for (int i = 0; i < 8; i++) begin
            exp_data[i] = 32'hB2B0_0000 | (i * 32'h0001_0011);
            do_txn(0, 1'b1, 32'h8000_0100 + i * 4, exp_data[i], 4'hF, rd, er);
        end
        req_i = 0;
        nresp = 0;
        resp_ready = 1'b1;
        req_wen = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 40 && nresp < 8; c++) begin
            if (valid[0] === 1'b1) begin
                checks += 2;
                if (rdata[0] !== exp_data[nresp]) begin
                    errors++;
                    $display("[TB] FAIL b2b_data%0d: got %h required %h", nresp, rdata[0], exp_data[nresp]);
                end
                if (c !== 1 + nresp * stride) begin
                    errors++;
                    $display("[TB] FAIL b2b_timing%0d: cycle %0d required %0d", nresp, c, 1 + nresp * stride);
                end
                nresp++;
            end
            if (req_i < 8) begin
                req_valid = 1'b1;
                req_addr  = 32'h8000_0100 + req_i * 4;
                if (ready[0] === 1'b1) req_i++;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (nresp !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d responses required 8", nresp);
        end
    endtask

    // Run every scenario in sequence, then print the summary line.
    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_wen    = 1'b0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        resp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
